vx_dispatch_arbiter: RTL and testbench

- Shares one execute-block input between NUM_REQS dispatch requesters.
- Requesters issue multi-beat packets framed by sop/eop, as produced when NUM_THREADS > NUM_LANES.
- Round-robin arbitration at packet boundaries; the grant is held (locked) from the first beat to the eop beat, so packets never interleave.
- Sits between the per-issue-slot dispatch outputs and a shared functional unit; the output is registered through a 2-entry skid buffer.

---
 rtl/vx_dispatch_arbiter_pkg.sv | 22 ++
 rtl/vx_rr_lock_arbiter.sv | 74 +++++++
 rtl/vx_dispatch_arbiter.sv | 135 +++++++++++++
 tb/tb_vx_dispatch_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vx_dispatch_arbiter_pkg.sv
// Shared types and constants for the dispatch arbiter slice.
// The lock FSM state encoding and the output buffer depth live here.
package VX_gpu_pkg;

    localparam int ARB_BUF_SIZE = 2;
    localparam int ARB_DATAW    = 64;
    localparam int ARB_SEL_W    = 2;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    // Beat layout at the default configuration (4 requesters, 64-bit payload).
    typedef struct packed {
        logic [ARB_DATAW-1:0] data;
        logic                 sop;
        logic                 eop;
        logic [ARB_SEL_W-1:0] sel;
    } arb_beat_t;

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// Round-robin requester selection with packet lock: the grant is held from
// the first accepted non-eop beat until the eop beat of the same requester.
module vx_rr_lock_arbiter
    import VX_gpu_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int SEL_W    = $clog2(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQS-1:0] valid,
    input  logic                fire,
    input  logic                eop,
    output logic [SEL_W-1:0]    winner,
    output logic                winner_valid,
    output logic                lock_active,
    output logic [SEL_W-1:0]    lock_idx
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQS - 1);

    arb_state_e       state_reg;
    logic [SEL_W-1:0] rr_ptr_reg;
    logic [SEL_W-1:0] lock_idx_reg;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] next_ptr;
    logic             scan_found;
    int               cand;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQS.
    always_comb begin
        scan_idx   = '0;
        scan_found = 1'b0;
        cand       = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = (int'(rr_ptr_reg) + k) % NUM_REQS;
            if (!scan_found && valid[cand]) begin
                scan_found = 1'b1;
                scan_idx   = SEL_W'(cand);
            end
        end
    end

    always_comb begin
        if (state_reg == ARB_LOCKED) begin
            winner       = lock_idx_reg;
            winner_valid = valid[lock_idx_reg];
        end else begin
            winner       = scan_idx;
            winner_valid = scan_found;
        end
        next_ptr = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ARB_UNLOCKED;
            rr_ptr_reg   <= '0;
            lock_idx_reg <= '0;
        end else if (fire) begin
            if (eop) begin
                state_reg  <= ARB_UNLOCKED;
                rr_ptr_reg <= next_ptr;
            end else begin
                state_reg    <= ARB_LOCKED;
                lock_idx_reg <= winner;
            end
        end
    end

    assign lock_active = (state_reg == ARB_LOCKED);
    assign lock_idx    = lock_idx_reg;

endmodule

// File: rtl/vx_dispatch_arbiter.sv
// Shares one execute-block input among NUM_REQS packet-framed requesters,
// with a 2-entry output buffer so req_ready never depends on out_ready.
module vx_dispatch_arbiter
    import VX_gpu_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = 64,
    parameter int REQ_SEL_W = $clog2(NUM_REQS),
    parameter int PERF_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [REQ_SEL_W-1:0]      out_sel,
    input  logic                      out_ready,
    output logic                      lock_active,
    output logic [REQ_SEL_W-1:0]      lock_idx,
    output logic [PERF_W-1:0]         perf_stalls
);

    localparam int CNT_W = $clog2(ARB_BUF_SIZE + 1);

    typedef struct packed {
        logic [DATAW-1:0]     data;
        logic                 sop;
        logic                 eop;
        logic [REQ_SEL_W-1:0] sel;
    } beat_t;

    logic [DATAW-1:0]     data_arr [NUM_REQS];
    logic [REQ_SEL_W-1:0] winner;
    logic                 winner_valid;
    logic                 fire;
    logic                 pop;
    logic                 can_accept_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic                 wr_ptr_reg;
    logic                 rd_ptr_reg;
    logic [PERF_W-1:0]    perf_reg;
    beat_t                in_beat;
    beat_t                head_beat;
    beat_t                buf_mem [ARB_BUF_SIZE];

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DATAW +: DATAW];
            assign req_ready[gi] = (winner == REQ_SEL_W'(gi)) && winner_valid && can_accept_reg;
        end
    endgenerate

    vx_rr_lock_arbiter #(
        .NUM_REQS (NUM_REQS),
        .SEL_W    (REQ_SEL_W)
    ) u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid        (req_valid),
        .fire         (fire),
        .eop          (req_eop[winner]),
        .winner       (winner),
        .winner_valid (winner_valid),
        .lock_active  (lock_active),
        .lock_idx     (lock_idx)
    );

    assign fire = winner_valid && can_accept_reg;
    assign pop  = (count_reg != '0) && out_ready;

    always_comb begin
        in_beat.data = data_arr[winner];
        in_beat.sop  = req_sop[winner];
        in_beat.eop  = req_eop[winner];
        in_beat.sel  = winner;
    end

    always_comb begin
        count_next = count_reg;
        case ({fire, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (fire) begin
            buf_mem[wr_ptr_reg] <= in_beat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg      <= '0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            can_accept_reg <= 1'b0;
            perf_reg       <= '0;
        end else begin
            count_reg      <= count_next;
            can_accept_reg <= (count_next != CNT_W'(ARB_BUF_SIZE));
            if (fire) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if ((|req_valid) && !fire && (perf_reg != '1)) begin
                perf_reg <= perf_reg + 1'b1;
            end
        end
    end

    assign head_beat   = buf_mem[rd_ptr_reg];
    assign out_valid   = (count_reg != '0);
    assign out_data    = head_beat.data;
    assign out_sop     = head_beat.sop;
    assign out_eop     = head_beat.eop;
    assign out_sel     = head_beat.sel;
    assign perf_stalls = perf_reg;

    // A new packet must not start while its own requester still holds the lock.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(fire && lock_active && req_sop[lock_idx]));

endmodule

// File: tb/tb_vx_dispatch_arbiter.sv
// Randomized packet traffic against a queue-based reference model, plus a
// PERF_W=4 instance that is held stalled to exercise counter saturation.
module tb_vx_dispatch_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_sop, req_eop, req_ready;
    logic [NR*DW-1:0] req_data;
    logic             out_valid, out_sop, out_eop, out_ready, lock_active;
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_sel, lock_idx;
    logic [31:0]      perf_stalls;

    logic [NR-1:0]    p4_valid, p4_sop, p4_eop, p4_ready;
    logic [NR*DW-1:0] p4_data;
    logic             p4_out_valid, p4_out_sop, p4_out_eop, p4_out_ready, p4_lock_active;
    logic [DW-1:0]    p4_out_data;
    logic [SW-1:0]    p4_out_sel, p4_lock_idx;
    logic [3:0]       p4_perf;

    vx_dispatch_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_sop(req_sop), .req_eop(req_eop),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_sel(out_sel), .out_ready(out_ready),
        .lock_active(lock_active), .lock_idx(lock_idx), .perf_stalls(perf_stalls)
    );

    vx_dispatch_arbiter #(.PERF_W(4)) dut_p4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(p4_valid), .req_data(p4_data), .req_sop(p4_sop), .req_eop(p4_eop),
        .req_ready(p4_ready),
        .out_valid(p4_out_valid), .out_data(p4_out_data), .out_sop(p4_out_sop), .out_eop(p4_out_eop),
        .out_sel(p4_out_sel), .out_ready(p4_out_ready),
        .lock_active(p4_lock_active), .lock_idx(p4_lock_idx), .perf_stalls(p4_perf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        bit          sop;
        bit          eop;
        int          sel;
    } mbeat_t;

    // Reference model state
    mbeat_t      mq[$];
    bit          m_lock;
    int          m_lock_idx;
    int          m_rr;
    longint      m_perf;
    bit          m_armed;
    int          p4_occ;
    int          p4_exp;

    // Per-requester packet generator
    int          g_len [NR];
    int          g_pos [NR];
    logic [63:0] g_data [NR];

    task automatic model_reset();
        mq.delete();
        m_lock = 0; m_lock_idx = 0; m_rr = 0; m_perf = 0; m_armed = 0;
        p4_occ = 0; p4_exp = 0;
        for (int i = 0; i < NR; i++) begin
            g_pos[i]  = 0;
            g_len[i]  = $urandom_range(1, 4);
            g_data[i] = {$urandom, $urandom};
        end
    endtask

    // Runs one clock cycle; entered and left just after a falling edge.
    task automatic cycle();
        int          w;
        bit          wv;
        bit          fire;
        bit          f4;
        logic [NR-1:0] er;
        mbeat_t      b;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = ($urandom_range(0, 99) < 60);
            req_sop[i]             = (g_pos[i] == 0);
            req_eop[i]             = (g_pos[i] == g_len[i] - 1);
            req_data[i*DW +: DW]   = g_data[i];
        end
        out_ready = ($urandom_range(0, 99) < 70);
        #1;
        w = 0; wv = 0;
        if (m_lock) begin
            w  = m_lock_idx;
            wv = req_valid[w];
        end else begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_rr + k) % NR;
                if (!wv && req_valid[c]) begin
                    wv = 1; w = c;
                end
            end
        end
        fire = wv && m_armed && (mq.size() < 2);
        er   = fire ? (NR'(1) << w) : '0;
        check_val("req_ready", 64'(req_ready), 64'(er));
        check_val("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_val("out_data", out_data, mq[0].data);
            check_val("out_sop", 64'(out_sop), 64'(mq[0].sop));
            check_val("out_eop", 64'(out_eop), 64'(mq[0].eop));
            check_val("out_sel", 64'(out_sel), 64'(mq[0].sel));
        end
        check_val("lock_active", 64'(lock_active), 64'(m_lock));
        check_val("lock_idx", 64'(lock_idx), 64'(m_lock_idx));
        check_val("perf_stalls", 64'(perf_stalls), 64'(m_perf));
        f4 = m_armed && (p4_occ < 2);
        check_val("p4_ready", 64'(p4_ready), f4 ? 64'd1 : 64'd0);
        check_val("p4_out_valid", 64'(p4_out_valid), 64'(p4_occ != 0));
        check_val("p4_perf", 64'(p4_perf), 64'(p4_exp));

        if (mq.size() != 0 && out_ready) mq.delete(0);
        if (fire) begin
            b.data = g_data[w]; b.sop = req_sop[w]; b.eop = req_eop[w]; b.sel = w;
            mq.push_back(b);
            if (b.eop) begin
                m_lock = 0;
                m_rr   = (w + 1) % NR;
            end else begin
                m_lock     = 1;
                m_lock_idx = w;
            end
            g_pos[w]++;
            if (g_pos[w] == g_len[w]) begin
                g_pos[w] = 0;
                g_len[w] = $urandom_range(1, 4);
            end
            g_data[w] = {$urandom, $urandom};
        end
        if ((|req_valid) && !fire && m_perf != 64'hFFFF_FFFF) m_perf++;
        if (f4) p4_occ++;
        else if (p4_exp < 15) p4_exp++;
        m_armed = 1;
        @(negedge clk);
    endtask

    initial begin
        bit did_reset;
        did_reset    = 0;
        reset_n      = 1'b0;
        req_valid    = '0; req_sop = '0; req_eop = '0; req_data = '0; out_ready = 1'b0;
        p4_valid     = 4'b0001; p4_sop = 4'b0001; p4_eop = 4'b0001; p4_out_ready = 1'b0;
        p4_data      = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_lock_active", 64'(lock_active), 64'd0);
        check_val("rst_lock_idx", 64'(lock_idx), 64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        check_val("rst_perf", 64'(perf_stalls), 64'd0);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!did_reset && cyc >= 1500 && m_lock) begin
                did_reset = 1;
                reset_n   = 1'b0;
                #1;
                check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
                check_val("mid_rst_lock_active", 64'(lock_active), 64'd0);
                check_val("mid_rst_req_ready", 64'(req_ready), 64'd0);
                check_val("mid_rst_perf", 64'(perf_stalls), 64'd0);
                check_val("mid_rst_p4_perf", 64'(p4_perf), 64'd0);
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
            end
            cycle();
        end
        check_val("mid_reset_seen", 64'(did_reset), 64'd1);
        check_val("p4_saturated", 64'(p4_perf), 64'd15);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
